aes_stream_ctrl: RTL and testbench
==================================

# aes_stream_ctrl

Sequencer between the 32-bit AXI4-Stream slave/master ports of the AES accelerator and the 128-bit AES core. It parses a command word at the start of each packet and loads keys. It assembles four stream words into one 128-bit block, starts the core, waits for done, and serializes the result back onto the output stream with TLAST preserved. It processes one block at a time, with no overlap between input collection, core run and output.

## Interface
Parameters:
- CMD_SETKEY, 8'h20, command code: load the following 128-bit key.
- CMD_ENC, 8'h10, command code: encrypt the following blocks.
- CMD_DEC, 8'h11, command code: decrypt the following blocks.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  32  input word.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  last word of packet.
- m_axis_tdata  out  32  output word.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  last word of output packet.
- core_key  out  128  key register to core.
- core_key_load  out  1  one-cycle pulse: core latches core_key.
- core_in  out  128  block to core.
- core_decrypt  out  1  0 = encrypt, 1 = decrypt; stable while core busy.
- core_start  out  1  one-cycle start pulse.
- core_out  in  128  core result, valid when core_done = 1.
- core_done  in  1  one-cycle completion pulse.
- err  out  1  sticky protocol error flag.
- err_clr  in  1  synchronous clear of err.

## Operation
- Command word: bits [31:24] hold the code; bits [23:0] are ignored. A word is accepted when tvalid and tready are both 1 on a rising edge.
- Word order: the first accepted word of a block or key maps to bits [127:96]; the fourth maps to [31:0]. Output emits [127:96] first.
- FSM states:
  - IDLE: tready = 1. Accept the command word.
    - CMD_SETKEY → KEY.
    - CMD_ENC or CMD_DEC → BLK_IN, latching core_decrypt.
    - Any other code, or any command word with tlast = 1 → err set; → DRAIN, or stay in IDLE if tlast = 1.
  - KEY: tready = 1. Collect 4 words, then → LOADKEY. If tlast arrives before the 4th word, or the 4th word arrives without tlast → err set, the key is not loaded, and the block goes to DRAIN or IDLE as appropriate.
  - LOADKEY: core_key_load = 1 for one cycle → IDLE. Key packets produce no output.
  - BLK_IN: tready = 1. Collect 4 words. On the 4th word, record the last flag from tlast → CORE. If tlast arrives on word 1–3 → err set, the partial block is discarded → IDLE.
  - CORE: tready = 0. core_start pulses in the first cycle only. Wait for core_done, latch core_out → BLK_OUT.
  - BLK_OUT: tvalid = 1, emitting 4 words. m_axis_tlast = 1 on the 4th word if the recorded last flag is set. After the 4th handshake: → IDLE if last, otherwise → BLK_IN.
  - DRAIN: tready = 1. Discard words until tlast is accepted → IDLE.
- core_key retains its value across packets. Reset clears it to 0.
- err_clr has priority below a same-cycle error set, so err remains 1.

## Timing
- Reset values:
  - s_axis_tready = 0
  - m_axis_tvalid = 0
  - m_axis_tlast = 0
  - m_axis_tdata = 0
  - core_start = 0
  - core_key_load = 0
  - core_decrypt = 0
  - core_key = 0
  - core_in = 0
  - err = 0
  - FSM in IDLE
- s_axis_tready rises in the first cycle after reset deasserts.
- All outputs are registered.
- core_start is asserted in the cycle after the 4th input word is accepted.
- The first output word is valid in the cycle after core_done.
- Latency, 4th input word to first output word, is core latency + 2 cycles.
- m_axis_tdata and m_axis_tlast hold stable while tvalid = 1 and tready = 0.
- The block does not depend on core_done arriving in the same cycle as core_start. A core_done outside CORE is ignored.
- Reset mid-operation returns the block to IDLE immediately: tvalid drops and partial blocks are lost. core_key is cleared.

## Configuration
- AES_CTRL_SWAP_EN:
  - Defined: every input data/key word is byte-swapped before assembly, {b0,b1,b2,b3} → {b3,b2,b1,b0}. Every output word is swapped the same way before driving m_axis_tdata. This matches little-endian word packing on the host side. The command word is never swapped.
  - Undefined: words pass unchanged.

## Test plan
Bench core stub: core_out = core_in ^ core_key for encrypt, or the same value ^ 128'h1 for decrypt, with core_done asserted 5 cycles after core_start.
- Set key 00010203_04050607_08090a0b_0c0d0e0f (cmd 0x20000000, tlast on the 4th key word) → core_key_load pulses once, no output, err = 0.
- Encrypt one block 00112233_44556677_8899aabb_ccddeeff with tlast → output words 00102030, 40506070, 8090a0b0, c0d0e0f0, tlast on the 4th, core_decrypt = 0.
- Decrypt a two-block packet → 8 output words, with tlast only on word 8. Slave tready oscillates 2 low / 6 high, and data is held stable across stalls.
- Command 0x33000000 followed by 3 words, tlast on the 3rd → err = 1, no output, no core_start. Then err_clr → err = 0.
- Encrypt packet with tlast on word 2 → err = 1, no core_start. The next valid packet is processed normally.
- With AES_CTRL_SWAP_EN defined, input word 0x33221100 → core_in[127:96] = 0x00112233. The output is swapped back.

Source files
------------

// File: rtl/aes_stream_ctrl.sv
// Stream sequencer between 32-bit AXI4-Stream ports and a 128-bit AES core: command parsing, key load, block assembly/serialization.
// Optional AES_CTRL_SWAP_EN: byte-swap every data/key word on the way in and every result word on the way out.
module aes_stream_ctrl #(
    parameter logic [7:0] CMD_SETKEY = 8'h20,
    parameter logic [7:0] CMD_ENC    = 8'h10,
    parameter logic [7:0] CMD_DEC    = 8'h11
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  s_axis_tdata,
    input  logic         s_axis_tvalid,
    output logic         s_axis_tready,
    input  logic         s_axis_tlast,
    output logic [31:0]  m_axis_tdata,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tready,
    output logic         m_axis_tlast,
    output logic [127:0] core_key,
    output logic         core_key_load,
    output logic [127:0] core_in,
    output logic         core_decrypt,
    output logic         core_start,
    input  logic [127:0] core_out,
    input  logic         core_done,
    output logic         err,
    input  logic         err_clr
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEY,
        ST_LOADKEY,
        ST_BLK_IN,
        ST_CORE,
        ST_BLK_OUT,
        ST_DRAIN
    } state_t;

    state_t state_reg, state_next;

    logic         s_tready_reg, s_tready_next;
    logic         m_tvalid_reg;
    logic         m_tlast_reg;
    logic [31:0]  m_tdata_reg;
    logic         core_start_reg, core_start_next;
    logic         core_key_load_reg, core_key_load_next;
    logic         core_decrypt_reg;
    logic [127:0] core_key_reg;
    logic [127:0] core_in_reg;
    logic         err_reg;
    logic         err_set;
    logic [95:0]  in_buf_reg;
    logic [1:0]   in_cnt_reg;
    logic [95:0]  out_buf_reg;
    logic [1:0]   out_cnt_reg;
    logic         last_flag_reg;

    logic         s_accept;
    logic         m_accept;
    logic [7:0]   cmd_code;
    logic         in_last_word;
    logic [31:0]  in_word;
    logic [127:0] core_out_sw;
    logic [127:0] block_full;

`ifdef AES_CTRL_SWAP_EN
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_in_swap
            assign in_word[8*gi +: 8] = s_axis_tdata[8*(3-gi) +: 8];
        end
        // byte gi%4 of word gi/4 takes byte 3-gi%4 of the same word
        for (gi = 0; gi < 16; gi++) begin : g_out_swap
            assign core_out_sw[8*gi +: 8] = core_out[8*((gi/4)*4 + 3 - (gi%4)) +: 8];
        end
    endgenerate
`else
    assign in_word     = s_axis_tdata;
    assign core_out_sw = core_out;
`endif

    assign s_accept     = s_axis_tvalid && s_tready_reg;
    assign m_accept     = m_tvalid_reg && m_axis_tready;
    assign cmd_code     = s_axis_tdata[31:24];
    assign in_last_word = (in_cnt_reg == 2'd3);
    assign block_full   = {in_buf_reg, in_word};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        err_set    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (s_accept) begin
                    if (s_axis_tlast) begin
                        err_set = 1'b1;
                    end else if (cmd_code == CMD_SETKEY) begin
                        state_next = ST_KEY;
                    end else if (cmd_code == CMD_ENC || cmd_code == CMD_DEC) begin
                        state_next = ST_BLK_IN;
                    end else begin
                        err_set    = 1'b1;
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_KEY: begin
                if (s_accept) begin
                    if (in_last_word) begin
                        if (s_axis_tlast) begin
                            state_next = ST_LOADKEY;
                        end else begin
                            err_set    = 1'b1;
                            state_next = ST_DRAIN;
                        end
                    end else if (s_axis_tlast) begin
                        err_set    = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_LOADKEY: state_next = ST_IDLE;
            ST_BLK_IN: begin
                if (s_accept) begin
                    if (in_last_word) begin
                        state_next = ST_CORE;
                    end else if (s_axis_tlast) begin
                        err_set    = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_CORE: begin
                if (core_done) begin
                    state_next = ST_BLK_OUT;
                end
            end
            ST_BLK_OUT: begin
                if (m_accept && out_cnt_reg == 2'd3) begin
                    state_next = last_flag_reg ? ST_IDLE : ST_BLK_IN;
                end
            end
            ST_DRAIN: begin
                if (s_accept && s_axis_tlast) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Registered outputs are derived from the upcoming state so they line up with it.
    always_comb begin
        s_tready_next      = (state_next == ST_IDLE) || (state_next == ST_KEY) ||
                             (state_next == ST_BLK_IN) || (state_next == ST_DRAIN);
        core_start_next    = (state_reg == ST_BLK_IN) && (state_next == ST_CORE);
        core_key_load_next = (state_next == ST_LOADKEY);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_tready_reg      <= 1'b0;
            m_tvalid_reg      <= 1'b0;
            m_tlast_reg       <= 1'b0;
            m_tdata_reg       <= 32'd0;
            core_start_reg    <= 1'b0;
            core_key_load_reg <= 1'b0;
            core_decrypt_reg  <= 1'b0;
            core_key_reg      <= 128'd0;
            core_in_reg       <= 128'd0;
            err_reg           <= 1'b0;
            in_buf_reg        <= 96'd0;
            in_cnt_reg        <= 2'd0;
            out_buf_reg       <= 96'd0;
            out_cnt_reg       <= 2'd0;
            last_flag_reg     <= 1'b0;
        end else begin
            s_tready_reg      <= s_tready_next;
            core_start_reg    <= core_start_next;
            core_key_load_reg <= core_key_load_next;

            if (s_accept && (state_reg == ST_KEY || state_reg == ST_BLK_IN)) begin
                in_buf_reg <= {in_buf_reg[63:0], in_word};
                in_cnt_reg <= s_axis_tlast ? 2'd0 : in_cnt_reg + 2'd1;
            end

            if (state_reg == ST_IDLE && state_next == ST_BLK_IN) begin
                core_decrypt_reg <= (cmd_code == CMD_DEC);
            end

            if (state_reg == ST_KEY && state_next == ST_LOADKEY) begin
                core_key_reg <= block_full;
            end

            if (core_start_next) begin
                core_in_reg   <= block_full;
                last_flag_reg <= s_axis_tlast;
            end

            if (state_reg == ST_CORE && core_done) begin
                m_tdata_reg  <= core_out_sw[127:96];
                out_buf_reg  <= core_out_sw[95:0];
                m_tvalid_reg <= 1'b1;
                m_tlast_reg  <= 1'b0;
                out_cnt_reg  <= 2'd0;
            end else if (m_accept) begin
                if (out_cnt_reg == 2'd3) begin
                    m_tvalid_reg <= 1'b0;
                    m_tlast_reg  <= 1'b0;
                    m_tdata_reg  <= 32'd0;
                end else begin
                    m_tdata_reg <= out_buf_reg[95:64];
                    out_buf_reg <= {out_buf_reg[63:0], 32'd0};
                    m_tlast_reg <= last_flag_reg && (out_cnt_reg == 2'd2);
                    out_cnt_reg <= out_cnt_reg + 2'd1;
                end
            end

            // a same-cycle error wins over the clear
            if (err_set) begin
                err_reg <= 1'b1;
            end else if (err_clr) begin
                err_reg <= 1'b0;
            end
        end
    end

    assign s_axis_tready = s_tready_reg;
    assign m_axis_tdata  = m_tdata_reg;
    assign m_axis_tvalid = m_tvalid_reg;
    assign m_axis_tlast  = m_tlast_reg;
    assign core_key      = core_key_reg;
    assign core_key_load = core_key_load_reg;
    assign core_in       = core_in_reg;
    assign core_decrypt  = core_decrypt_reg;
    assign core_start    = core_start_reg;
    assign err           = err_reg;

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Bench for aes_stream_ctrl: packet-level reference model, XOR core stub with 5-cycle latency, per-cycle output compare.
module tb_aes_stream_ctrl;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [31:0]  s_axis_tdata = 32'd0;
    logic         s_axis_tvalid = 1'b0;
    logic         s_axis_tready;
    logic         s_axis_tlast = 1'b0;
    logic [31:0]  m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready = 1'b0;
    logic         m_axis_tlast;
    logic [127:0] core_key;
    logic         core_key_load;
    logic [127:0] core_in;
    logic         core_decrypt;
    logic         core_start;
    logic [127:0] core_out;
    logic         core_done;
    logic         err;
    logic         err_clr = 1'b0;

    aes_stream_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .core_key      (core_key),
        .core_key_load (core_key_load),
        .core_in       (core_in),
        .core_decrypt  (core_decrypt),
        .core_start    (core_start),
        .core_out      (core_out),
        .core_done     (core_done),
        .err           (err),
        .err_clr       (err_clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Core stub: XOR with key (and bit 0 for decrypt), done 5 cycles after start.
    logic [4:0] start_sr;
    always @(posedge clk or posedge reset) begin
        if (reset) start_sr <= 5'd0;
        else       start_sr <= {start_sr[3:0], core_start};
    end
    assign core_done = start_sr[4];
    assign core_out  = core_in ^ core_key ^ {127'd0, core_decrypt};

    // Sink: tready 2 cycles low / 6 high.
    logic sink_en = 1'b1;
    int   tr_ph = 0;
    always @(posedge clk) begin
        #1;
        m_axis_tready = sink_en && ((tr_ph % 8) >= 2);
        tr_ph++;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [31:0] host(input logic [31:0] w);
`ifdef AES_CTRL_SWAP_EN
        return bswap(w);
`else
        return w;
`endif
    endfunction

    // Reference model state
    logic [127:0] m_key = 128'd0;
    logic         m_err = 1'b0;
    int           exp_loads = 0;
    int           exp_starts = 0;
    logic [31:0]  exp_data[$];
    logic         exp_last[$];
    logic [127:0] exp_keyq[$];
    logic         exp_decq[$];
    logic [31:0]  pkt[$];

    // Observed
    int           n_loads = 0;
    int           n_starts = 0;
    int           acc_cyc = 0;
    int           first_valid_cyc = 0;
    int           start_cyc = 0;
    logic [127:0] core_in_seen = 128'd0;
    logic [31:0]  out_log[$];
    logic         last_log[$];

    task automatic model_packet();
        int n;
        int nd;
        logic [7:0]   code;
        logic [127:0] blk;
        logic [127:0] res;
        n    = pkt.size();
        code = pkt[0][31:24];
        if (n == 1) begin
            m_err = 1'b1;
            return;
        end
        nd = n - 1;
        if (code == 8'h20) begin
            if (nd == 4) begin
                m_key = {host(pkt[1]), host(pkt[2]), host(pkt[3]), host(pkt[4])};
                exp_keyq.push_back(m_key);
                exp_loads++;
            end else begin
                m_err = 1'b1;
            end
        end else if (code == 8'h10 || code == 8'h11) begin
            for (int b = 0; b < nd / 4; b++) begin
                blk = {host(pkt[1+4*b]), host(pkt[2+4*b]), host(pkt[3+4*b]), host(pkt[4+4*b])};
                res = blk ^ m_key ^ ((code == 8'h11) ? 128'd1 : 128'd0);
                exp_decq.push_back(code == 8'h11);
                exp_starts++;
                for (int k = 0; k < 4; k++) begin
                    exp_data.push_back(host(res[127-32*k -: 32]));
                    exp_last.push_back((k == 3) && (b == nd / 4 - 1) && (nd % 4 == 0));
                end
            end
            if (nd % 4 != 0) m_err = 1'b1;
        end else begin
            m_err = 1'b1;
        end
    endtask

    // Per-cycle compare against the model queues
    logic        stall_prev = 1'b0;
    logic [31:0] stall_data = 32'd0;
    logic        stall_last = 1'b0;
    logic        prev_valid = 1'b0;
    always @(negedge clk) begin
        logic [31:0] ed;
        logic        el;
        if (reset) begin
            stall_prev = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (m_axis_tvalid && !prev_valid) first_valid_cyc = cyc;
            if (stall_prev) begin
                check("hold_valid", m_axis_tvalid, 1);
                check("hold_data", m_axis_tdata, stall_data);
                check("hold_last", m_axis_tlast, stall_last);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_data.size() == 0) begin
                    check("unexpected_out", m_axis_tvalid, 0);
                end else begin
                    ed = exp_data.pop_front();
                    el = exp_last.pop_front();
                    check("out_data", m_axis_tdata, ed);
                    check("out_last", m_axis_tlast, el);
                    out_log.push_back(m_axis_tdata);
                    last_log.push_back(m_axis_tlast);
                    $display("out word data=%h last=%b cycle=%0d", m_axis_tdata, m_axis_tlast, cyc);
                end
            end
            stall_prev = m_axis_tvalid && !m_axis_tready;
            stall_data = m_axis_tdata;
            stall_last = m_axis_tlast;
            prev_valid = m_axis_tvalid;
            if (core_start) begin
                n_starts++;
                start_cyc    = cyc;
                core_in_seen = core_in;
            end
            if (core_key_load) begin
                n_loads++;
                if (exp_keyq.size() != 0) check("key_value", core_key, exp_keyq.pop_front());
                else check("unexpected_load", core_key_load, 0);
            end
            if (core_done && exp_decq.size() != 0) begin
                check("core_decrypt", core_decrypt, exp_decq.pop_front());
            end
        end
    end

    task automatic send_word(input logic [31:0] d, input logic l);
        int waitc;
        waitc = 0;
        @(negedge clk);
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        while (!s_axis_tready && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        if (!s_axis_tready) begin
            check("tready_timeout", s_axis_tready, 1);
            return;
        end
        acc_cyc = cyc;
        @(posedge clk);
    endtask

    task automatic run_packet();
        int w;
        model_packet();
        out_log.delete();
        last_log.delete();
        for (int i = 0; i < pkt.size(); i++) send_word(pkt[i], i == pkt.size() - 1);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        w = 0;
        while (exp_data.size() != 0 && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (exp_data.size() != 0) check("drain_timeout", exp_data.size(), 0);
        repeat (12) @(negedge clk);
        check("pkt_err", err, m_err);
        check("pkt_starts", n_starts, exp_starts);
        check("pkt_loads", n_loads, exp_loads);
        $display("packet cmd=%h words=%0d outputs=%0d err=%b", pkt[0], pkt.size(), out_log.size(), err);
    endtask

    task automatic clear_err();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_err   = 1'b0;
        check("err_cleared", err, 0);
    endtask

    initial begin
        int nl;
        int w;
        int starts_before;
        repeat (3) @(negedge clk);
        check("rst_tready", s_axis_tready, 0);
        check("rst_m_side", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, 0);
        check("rst_core_ctl", {core_start, core_key_load, core_decrypt, err}, 0);
        check("rst_core_key", core_key, 0);
        check("rst_core_in", core_in, 0);
        reset = 1'b0;
        @(negedge clk);
        check("tready_after_reset", s_axis_tready, 1);

        // Key load
        pkt = '{32'h20000000, 32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f};
        run_packet();
        check("t1_loads", n_loads, 1);
        check("t1_no_output", out_log.size(), 0);
`ifdef AES_CTRL_SWAP_EN
        check("t1_key", core_key, 128'h03020100_07060504_0b0a0908_0f0e0d0c);
`else
        check("t1_key", core_key, 128'h00010203_04050607_08090a0b_0c0d0e0f);
`endif

        // Single-block encrypt
        pkt = '{32'h10000000, 32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
        run_packet();
        check("t2_w0", out_log[0], 32'h00102030);
        check("t2_w1", out_log[1], 32'h40506070);
        check("t2_w2", out_log[2], 32'h8090a0b0);
        check("t2_w3", out_log[3], 32'hc0d0e0f0);
        check("t2_last3", last_log[3], 1);
        check("t2_last0", last_log[0], 0);
        check("t2_decrypt", core_decrypt, 0);
        check("t2_start_lat", start_cyc - acc_cyc, 1);
        check("t2_out_lat", first_valid_cyc - acc_cyc, 7);

        // Two-block decrypt
        pkt = '{32'h11000000, 32'h0, 32'h0, 32'h0, 32'h0,
                32'hdeadbeef, 32'h01234567, 32'h89abcdef, 32'hfedcba98};
        run_packet();
        check("t3_count", out_log.size(), 8);
        nl = 0;
        foreach (last_log[i]) if (last_log[i]) nl++;
        check("t3_nlast", nl, 1);
        check("t3_last7", last_log[7], 1);
        check("t3_decrypt", core_decrypt, 1);
`ifndef AES_CTRL_SWAP_EN
        check("t3_w3", out_log[3], 32'h0c0d0e0e);
`endif

        // Unknown command
        starts_before = n_starts;
        pkt = '{32'h33000000, 32'h1, 32'h2, 32'h3};
        run_packet();
        check("t4_err", err, 1);
        check("t4_no_start", n_starts, starts_before);
        clear_err();

        // Encrypt with early tlast, then a good packet
        starts_before = n_starts;
        pkt = '{32'h10000000, 32'haaaa5555, 32'h5555aaaa};
        run_packet();
        check("t5_err", err, 1);
        check("t5_no_start", n_starts, starts_before);
        clear_err();
        pkt = '{32'h10000000, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        run_packet();
        check("t5_recover_count", out_log.size(), 4);

        // Malformed key packets: short, then 4th word without tlast
        pkt = '{32'h20000000, 32'hffffffff, 32'heeeeeeee};
        run_packet();
        clear_err();
        pkt = '{32'h20000000, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
        run_packet();
        clear_err();

        // Word packing into core_in
        pkt = '{32'h10000000, 32'h33221100, 32'h1, 32'h2, 32'h3};
        run_packet();
`ifdef AES_CTRL_SWAP_EN
        check("t7_core_in_hi", core_in_seen[127:96], 32'h00112233);
`else
        check("t7_core_in_hi", core_in_seen[127:96], 32'h33221100);
`endif

        // Error set beats same-cycle clear
        @(negedge clk);
        err_clr = 1'b1;
        send_word(32'h10000000, 1'b1);
        @(negedge clk);
        err_clr       = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        check("t8_err_priority", err, 1);
        clear_err();

        // Reset while a result is waiting on a stalled sink
        sink_en = 1'b0;
        exp_decq.push_back(1'b0);
        exp_starts++;
        send_word(32'h10000000, 1'b0);
        send_word(32'h01010101, 1'b0);
        send_word(32'h02020202, 1'b0);
        send_word(32'h03030303, 1'b0);
        send_word(32'h04040404, 1'b1);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        w = 0;
        while (!m_axis_tvalid && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("t9_valid_seen", m_axis_tvalid, 1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("t9_valid_drop", m_axis_tvalid, 0);
        check("t9_tready_drop", s_axis_tready, 0);
        check("t9_key_cleared", core_key, 0);
        repeat (2) @(negedge clk);
        reset   = 1'b0;
        sink_en = 1'b1;
        m_key   = 128'd0;
        m_err   = 1'b0;
        exp_data.delete();
        exp_last.delete();
        exp_decq.delete();
        pkt = '{32'h10000000, 32'h12345678, 32'h9abcdef0, 32'h0, 32'hffffffff};
        run_packet();
        check("t9_zero_key_w0", out_log[0], 32'h12345678);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
